// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: access-size codes and the access-unit state encoding.
// Also consumed by the pipeline MEM-stage decode.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW_RD,
        RMW_WR,
        RESP
    } mauState_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the data-memory word port of the MEM-stage access unit.
// master = pipeline side and DM model, slave = the access unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_write;
    logic              dm_read;
    logic [31:0]       dm_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_wdata, dm_write, dm_read
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_wdata, dm_write, dm_read
    );
endinterface

// File: rtl/mau_lane_unit.sv
// Big-endian lane selection: extends the addressed byte/half of a DM word for loads
// and splices store data into that lane for read-modify-write.
module mau_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergeWord
);
    logic [4:0]  byteSh;
    logic [4:0]  halfSh;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Offset 0 is the most significant byte, so the shift is 24 - 8*offset.
    assign byteSh   = {~offset, 3'b000};
    assign halfSh   = {~offset[1], 4'b0000};
    assign laneByte = 8'(word >> byteSh);
    assign laneHalf = 16'(word >> halfSh);

    always_comb begin
        loadData  = word;
        mergeWord = wdata;
        case (size)
            SIZE_B: begin
                loadData  = isUnsigned ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
                mergeWord = (word & ~(32'h0000_00FF << byteSh)) | ({24'h0, wdata[7:0]} << byteSh);
            end
            SIZE_H: begin
                loadData  = isUnsigned ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
                mergeWord = (word & ~(32'h0000_FFFF << halfSh)) | ({16'h0, wdata[15:0]} << halfSh);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: turns byte/half/word loads and stores into DM word
// transactions, using read-modify-write for sub-word stores.
//
// state  | meaning
// IDLE   | ready for a request; error check evaluated on accept
// LD     | DM read, addressed lane extended into the response
// ST     | full-word DM write
// RMW_RD | DM read of the word holding the sub-word store target
// RMW_WR | DM write of the merged word
// RESP   | response presented until resp_ready
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    mauState_t         state;
    mauState_t         stateNext;
    logic [ADDR_W-1:0] addrQ;
    logic [1:0]        sizeQ;
    logic              unsQ;
    logic [31:0]       wdataQ;
    logic [31:0]       mergeQ;
    logic [31:0]       rdataQ;
    logic              errQ;
    logic              reqErr;
    logic              accept;
    logic [31:0]       laneWord;
    logic [31:0]       loadData;
    logic [31:0]       mergeWord;

    always_comb begin
        reqErr = 1'b0;
        case (bus.req_size)
            SIZE_H:  reqErr = bus.req_addr[0];
            SIZE_W:  reqErr = (bus.req_addr[1:0] != 2'b00);
            SIZE_X:  reqErr = 1'b1;
            default: reqErr = 1'b0;
        endcase
        if ({bus.req_addr[ADDR_W-1:2], 2'b00} > LAST_WORD)
            reqErr = 1'b1;
    end

    assign accept = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        bus.dm_read    = 1'b0;
        bus.dm_write   = 1'b0;
        bus.dm_wdata   = '0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (reqErr)                   stateNext = RESP;
                    else if (!bus.req_we)         stateNext = LD;
                    else if (bus.req_size == SIZE_W) stateNext = ST;
                    else                          stateNext = RMW_RD;
                end
            end
            LD: begin
                bus.dm_read = 1'b1;
                stateNext   = RESP;
            end
            ST: begin
                bus.dm_write = 1'b1;
                bus.dm_wdata = wdataQ;
                stateNext    = RESP;
            end
            RMW_RD: begin
                bus.dm_read = 1'b1;
                stateNext   = RMW_WR;
            end
            RMW_WR: begin
                bus.dm_write = 1'b1;
                bus.dm_wdata = mergeWord;
                stateNext    = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrQ  <= '0;
            sizeQ  <= SIZE_B;
            unsQ   <= 1'b0;
            wdataQ <= '0;
            mergeQ <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if (accept) begin
                addrQ  <= bus.req_addr;
                sizeQ  <= bus.req_size;
                unsQ   <= bus.req_unsigned;
                wdataQ <= bus.req_wdata;
                rdataQ <= '0;
                errQ   <= reqErr;
            end
            if (state == LD)
                rdataQ <= loadData;
            if (state == RMW_RD)
                mergeQ <= bus.dm_rdata;
        end
    end

    // Loads extend straight from the DM read port; the merge works on the captured word.
    assign laneWord = (state == RMW_WR) ? mergeQ : bus.dm_rdata;

    mau_lane_unit u_lane (
        .word       (laneWord),
        .offset     (addrQ[1:0]),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .wdata      (wdataQ),
        .loadData   (loadData),
        .mergeWord  (mergeWord)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.dm_addr    = {addrQ[ADDR_W-1:2], 2'b00};
    assign bus.resp_rdata = rdataQ;
    assign bus.resp_err   = errQ;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference memory predicts each
// response; a negedge monitor checks responses, latency and DM traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] addr;
        int          acceptCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdCnt = 0;
    int          wrCnt = 0;
    logic        firstSeen = 1'b0;
    logic        expectIdle = 1'b0;
    logic        forceStall = 1'b0;
    logic [7:0]  dmMem  [128];
    logic [7:0]  refMem [128];
    exp_t        sbq[$];
    logic [6:0]  dmIdx;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkBit(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Data memory: big-endian 4-byte window, combinational read, write on the clock edge.
    assign dmIdx = {bus.dm_addr[6:2], 2'b00};
    assign bus.dm_rdata = {dmMem[dmIdx], dmMem[dmIdx + 7'd1], dmMem[dmIdx + 7'd2], dmMem[dmIdx + 7'd3]};

    initial begin
        #1;
        for (int i = 0; i < 128; i++) dmMem[i] = refMem[i];
        forever begin
            @(posedge clk);
            if (bus.dm_write) begin
                dmMem[dmIdx]        <= bus.dm_wdata[31:24];
                dmMem[dmIdx + 7'd1] <= bus.dm_wdata[23:16];
                dmMem[dmIdx + 7'd2] <= bus.dm_wdata[15:8];
                dmMem[dmIdx + 7'd3] <= bus.dm_wdata[7:0];
            end
        end
    end

    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = forceStall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: byte-addressed memory, big-endian, predicts the whole response.
    task automatic model(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        e = '{rdata: 32'h0, err: 1'b0, lat: 0, reads: 0, writes: 0, addr: 32'h0, acceptCyc: 0};
        e.addr = {addr[31:2], 2'b00};
        if (size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)
            || e.addr > 32'd124) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
        a = int'(addr[6:0]);
        if (!we) begin
            e.lat   = 2;
            e.reads = 1;
            if (size == 2'b00) begin
                b = refMem[a];
                e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end else if (size == 2'b01) begin
                h = {refMem[a], refMem[a + 1]};
                e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end else begin
                e.rdata = {refMem[a], refMem[a + 1], refMem[a + 2], refMem[a + 3]};
            end
        end else begin
            e.writes = 1;
            if (size == 2'b10) begin
                e.lat = 2;
                refMem[a]     = wdata[31:24];
                refMem[a + 1] = wdata[23:16];
                refMem[a + 2] = wdata[15:8];
                refMem[a + 3] = wdata[7:0];
            end else begin
                e.lat   = 3;
                e.reads = 1;
                if (size == 2'b00) begin
                    refMem[a] = wdata[7:0];
                end else begin
                    refMem[a]     = wdata[15:8];
                    refMem[a + 1] = wdata[7:0];
                end
            end
        end
    endtask

    task automatic waitReady(output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles", guard);
        end
    endtask

    task automatic doReq(bit we, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        bit   ok;
        waitReady(ok);
        if (!ok) return;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        model(we, size, uns, addr, wdata, e);
        e.acceptCyc = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() > 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses still outstanding", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(string tag);
        chkBit({tag, "_req_ready"},  bus.req_ready,  1'b1);
        chkBit({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        chkBit({tag, "_resp_err"},   bus.resp_err,   1'b0);
        chkBit({tag, "_dm_write"},   bus.dm_write,   1'b0);
        chkBit({tag, "_dm_read"},    bus.dm_read,    1'b0);
        chk({tag, "_resp_rdata"},    bus.resp_rdata, 32'h0);
        chk({tag, "_dm_addr"},       bus.dm_addr,    32'h0);
        chk({tag, "_dm_wdata"},      bus.dm_wdata,   32'h0);
    endtask

    task automatic checkMemImage(string name);
        int mism = 0;
        for (int i = 0; i < 128; i++)
            if (dmMem[i] !== refMem[i]) mism++;
        chk(name, 32'(mism), 32'h0);
    endtask

    // Monitor: every cycle a response is visible it must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (expectIdle) begin
                chkBit("idle_after_resp", bus.req_ready, 1'b1);
                expectIdle = 1'b0;
            end
            if (bus.dm_read)  rdCnt++;
            if (bus.dm_write) wrCnt++;
            if ((bus.dm_read || bus.dm_write) && sbq.size() > 0)
                chk("dm_addr", bus.dm_addr, sbq[0].addr);
            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    if (!firstSeen) begin
                        chk("latency",   32'(cyc - sbq[0].acceptCyc), 32'(sbq[0].lat));
                        chk("dm_reads",  32'(rdCnt),  32'(sbq[0].reads));
                        chk("dm_writes", 32'(wrCnt),  32'(sbq[0].writes));
                        firstSeen = 1'b1;
                    end
                    chk("resp_rdata", bus.resp_rdata, sbq[0].rdata);
                    chkBit("resp_err", bus.resp_err, sbq[0].err);
                    chkBit("req_ready_busy", bus.req_ready, 1'b0);
                    if (bus.resp_ready) begin
                        void'(sbq.pop_front());
                        firstSeen  = 1'b0;
                        rdCnt      = 0;
                        wrCnt      = 0;
                        expectIdle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] preload;
        int          guard;
        bit          ok;
        logic [1:0]  rsize;
        int          r;
        logic [31:0] raddr;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SIZE_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        preload = 64'h1122_3344_8566_7788;
        for (int i = 0; i < 128; i++) refMem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) refMem[i] = preload[63 - 8*i -: 8];

        #3;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on the preloaded image.
        doReq(1'b0, SIZE_B, 1'b0, 32'd4,   32'h0);
        doReq(1'b0, SIZE_H, 1'b1, 32'd6,   32'h0);
        doReq(1'b0, SIZE_W, 1'b0, 32'd0,   32'h0);
        doReq(1'b1, SIZE_B, 1'b0, 32'd1,   32'hFFFF_FFAB);
        doReq(1'b0, SIZE_W, 1'b0, 32'd0,   32'h0);
        doReq(1'b0, SIZE_H, 1'b1, 32'd2,   32'h0);
        doReq(1'b1, SIZE_H, 1'b0, 32'd1,   32'h1234_5678);
        doReq(1'b0, SIZE_W, 1'b0, 32'd124, 32'h0);
        doReq(1'b0, SIZE_W, 1'b0, 32'd128, 32'h0);
        doReq(1'b1, SIZE_X, 1'b0, 32'd8,   32'h0);
        doReq(1'b1, SIZE_H, 1'b0, 32'd6,   32'hCAFE_BEEF);
        doReq(1'b0, SIZE_H, 1'b0, 32'd6,   32'h0);
        drain();
        checkMemImage("mem_after_directed");

        // Backpressure: response must hold for five stalled cycles.
        forceStall = 1'b1;
        doReq(1'b0, SIZE_W, 1'b0, 32'd4, 32'h0);
        guard = 0;
        while (!bus.resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chkBit("stall_resp_valid", bus.resp_valid, 1'b1);
        repeat (5) @(negedge clk);
        forceStall = 1'b0;
        drain();

        // Reset while the sub-word store is still reading.
        waitReady(ok);
        if (ok) begin
            bus.req_valid    = 1'b1;
            bus.req_we       = 1'b1;
            bus.req_size     = SIZE_B;
            bus.req_unsigned = 1'b0;
            bus.req_addr     = 32'd2;
            bus.req_wdata    = 32'h0000_005A;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            chkBit("abort_in_rmw_rd", bus.dm_read, 1'b1);
            #1;
            rst_n = 1'b0;
            #1;
            checkResetOutputs("abort");
            repeat (3) begin
                @(negedge clk);
                chkBit("abort_dm_write", bus.dm_write, 1'b0);
            end
            rst_n = 1'b1;
            rdCnt = 0;
            wrCnt = 0;
            firstSeen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chkBit("abort_idle_dm_write", bus.dm_write, 1'b0);
            end
            checkMemImage("mem_after_abort");
        end

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            rsize = (r == 0) ? SIZE_X : 2'(r % 3);
            raddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 131));
            doReq(bit'($urandom_range(0, 1)), rsize, bit'($urandom_range(0, 1)), raddr, $urandom);
        end
        drain();
        checkMemImage("mem_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
